// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the RAMHelper port and ram_port_arbiter.
// The arbiter uses the slave view; the core top level (or a bench) uses the master view.
interface ram_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic        if_resp_ready;
    logic [31:0] if_resp_data;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [63:0] mem_wmask;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [63:0] mem_resp_data;

    logic        ram_en;
    logic [63:0] ram_ridx;
    logic [63:0] ram_rdata;
    logic [63:0] ram_widx;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic        ram_wen;

    modport slave (
        input  if_req_valid, if_addr, if_resp_ready,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ram_rdata,
        output ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen
    );

    modport master (
        output if_req_valid, if_addr, if_resp_ready,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ram_rdata,
        input  ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single RAMHelper port between instruction fetch and the load/store unit.
// Define ARB_RR_EN for round-robin arbitration instead of MEM priority with IF starvation override.
module ram_port_arbiter #(
    parameter logic [63:0] PC_BASE    = 64'h0000_0000_8000_0000,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg;
    logic        owner_mem_reg;
    logic        sel_hi_reg;
    logic        wr_reg;
    logic        if_resp_valid_reg;
    logic        mem_resp_valid_reg;
    logic [63:0] hold_reg;

    logic        owner_resp_ready;
    logic        window_open;
    logic        if_pick;
    logic        grant_if;
    logic        grant_mem;
    logic        grant;
    logic        wr_grant;
    logic [63:0] req_addr;
    logic [63:0] req_idx;
    logic [63:0] resp_if_word;
    logic [63:0] resp_mem_word;
    logic [63:0] resp_word;
    logic [63:0] out_word;

    assign owner_resp_ready = owner_mem_reg ? bus.mem_resp_ready : bus.if_resp_ready;
    assign window_open = !rst && ((state_reg == IDLE) || ((state_reg == RESP) && owner_resp_ready));

`ifdef ARB_RR_EN
    // Set means IF took the last grant, so MEM wins the next tie.
    logic last_if_reg;

    assign if_pick = !bus.mem_req_valid || !last_if_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_if_reg <= 1'b1;
        end else if (grant) begin
            last_if_reg <= grant_if;
        end
    end
`else
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_reg;

    assign if_pick = !bus.mem_req_valid || (starve_reg == STARVE_LIM);

    // Counts MEM wins while IF is waiting; any cycle without an IF request forgives the debt.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
        end else if (!bus.if_req_valid || grant_if) begin
            starve_reg <= '0;
        end else if (grant_mem && (starve_reg != STARVE_LIM)) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end
`endif

    assign grant_if  = window_open && bus.if_req_valid && if_pick;
    assign grant_mem = window_open && bus.mem_req_valid && !grant_if;
    assign grant     = grant_if || grant_mem;
    assign wr_grant  = grant_mem && bus.mem_wen;

    // Addresses below PC_BASE simply wrap; the subtraction is modulo 2^64.
    assign req_addr = grant_mem ? bus.mem_addr : bus.if_addr;
    assign req_idx  = (req_addr - PC_BASE) >> 3;

    assign bus.if_req_ready  = grant_if;
    assign bus.mem_req_ready = grant_mem;
    assign bus.ram_en        = grant;
    assign bus.ram_ridx      = grant ? req_idx : 64'h0;
    assign bus.ram_wen       = wr_grant;
    assign bus.ram_widx      = wr_grant ? req_idx : 64'h0;
    assign bus.ram_wdata     = wr_grant ? bus.mem_wdata : 64'h0;
    assign bus.ram_wmask     = wr_grant ? bus.mem_wmask : 64'h0;

    assign resp_if_word  = sel_hi_reg ? {32'h0, bus.ram_rdata[63:32]} : {32'h0, bus.ram_rdata[31:0]};
    assign resp_mem_word = wr_reg ? 64'h0 : bus.ram_rdata;
    assign resp_word     = owner_mem_reg ? resp_mem_word : resp_if_word;

    always_comb begin
        out_word = 64'h0;
        case (state_reg)
            RESP:    out_word = resp_word;
            HOLD:    out_word = hold_reg;
            default: out_word = 64'h0;
        endcase
    end

    assign bus.if_resp_valid  = if_resp_valid_reg;
    assign bus.mem_resp_valid = mem_resp_valid_reg;
    assign bus.if_resp_data   = if_resp_valid_reg ? out_word[31:0] : 32'h0;
    assign bus.mem_resp_data  = mem_resp_valid_reg ? out_word : 64'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            owner_mem_reg      <= 1'b0;
            sel_hi_reg         <= 1'b0;
            wr_reg             <= 1'b0;
            if_resp_valid_reg  <= 1'b0;
            mem_resp_valid_reg <= 1'b0;
            hold_reg           <= 64'h0;
        end else begin
            // RAM read data is only valid for one cycle, so keep a copy for a stalled owner.
            if (state_reg == RESP) begin
                hold_reg <= resp_word;
            end

            if (grant) begin
                state_reg          <= RESP;
                owner_mem_reg      <= grant_mem;
                sel_hi_reg         <= req_addr[2];
                wr_reg             <= wr_grant;
                if_resp_valid_reg  <= grant_if;
                mem_resp_valid_reg <= grant_mem;
            end else begin
                case (state_reg)
                    RESP: begin
                        if (owner_resp_ready) begin
                            state_reg          <= IDLE;
                            if_resp_valid_reg  <= 1'b0;
                            mem_resp_valid_reg <= 1'b0;
                        end else begin
                            state_reg <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (owner_resp_ready) begin
                            state_reg          <= IDLE;
                            if_resp_valid_reg  <= 1'b0;
                            mem_resp_valid_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg          <= IDLE;
                        if_resp_valid_reg  <= 1'b0;
                        mem_resp_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a small registered-read RAM model.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter_if bus();

    ram_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAMHelper stand-in: read data appears the cycle after ram_en.
    logic [63:0] ram_mem [0:63];
    always @(posedge clk) begin
        if (rst) begin
            bus.ram_rdata <= 64'h0;
            for (int i = 0; i < 64; i++) ram_mem[i] <= 64'h0;
            ram_mem[0] <= 64'hCAFE_F00D_1234_5678;
            ram_mem[1] <= 64'h5555_AAAA_6666_9999;
            ram_mem[3] <= 64'h0123_4567_89AB_CDEF;
        end else if (bus.ram_en) begin
            bus.ram_rdata <= ram_mem[bus.ram_ridx[5:0]];
            if (bus.ram_wen)
                ram_mem[bus.ram_widx[5:0]] <= (ram_mem[bus.ram_widx[5:0]] & ~bus.ram_wmask)
                                              | (bus.ram_wdata & bus.ram_wmask);
        end
    end

    task automatic idle_inputs();
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = 64'h0;
        bus.if_resp_ready  = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_addr       = 64'h0;
        bus.mem_wen        = 1'b0;
        bus.mem_wdata      = 64'h0;
        bus.mem_wmask      = 64'h0;
        bus.mem_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.mem_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.if_req_ready !== 1'b0) begin failures++; $display("FAIL reset_if_ready got=%0h exp=0", bus.if_req_ready); end
        checks++; if (bus.mem_req_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%0h exp=0", bus.mem_req_ready); end
        checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%0h exp=0", bus.ram_en); end
        checks++; if (bus.ram_wen !== 1'b0) begin failures++; $display("FAIL reset_ram_wen got=%0h exp=0", bus.ram_wen); end
        checks++; if (bus.if_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_if_rvalid got=%0h exp=0", bus.if_resp_valid); end
        checks++; if (bus.mem_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_rvalid got=%0h exp=0", bus.mem_resp_valid); end
        checks++; if (bus.mem_resp_data !== 64'h0) begin failures++; $display("FAIL reset_mem_rdata got=%0h exp=0", bus.mem_resp_data); end
        checks++; if (dut.state_reg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state_reg); end
        checks++; if (dut.hold_reg !== 64'h0) begin failures++; $display("FAIL reset_hold got=%0h exp=0", dut.hold_reg); end
`ifndef ARB_RR_EN
        checks++; if (dut.starve_reg !== 3'd0) begin failures++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_reg); end
`endif
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL reset_idle_en got=%0h exp=0", bus.ram_en); end
        $display("test_reset done");
    endtask

    task automatic test_if_back_to_back();
        @(negedge clk);
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0000;
        bus.if_resp_ready = 1'b1;
        #1;
        checks++; if (bus.if_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0h exp=1", bus.if_req_ready); end
        checks++; if (bus.ram_en !== 1'b1) begin failures++; $display("FAIL b2b_en0 got=%0h exp=1", bus.ram_en); end
        checks++; if (bus.ram_ridx !== 64'h0) begin failures++; $display("FAIL b2b_ridx0 got=%0h exp=0", bus.ram_ridx); end
        checks++; if (bus.mem_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_mem_ready got=%0h exp=0", bus.mem_req_ready); end
        @(negedge clk);
        bus.if_addr = 64'h8000_0004;
        #1;
        checks++; if (bus.if_resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid0 got=%0h exp=1", bus.if_resp_valid); end
        checks++; if (bus.if_resp_data !== 32'h1234_5678) begin failures++; $display("FAIL b2b_data0 got=%0h exp=12345678", bus.if_resp_data); end
        checks++; if (bus.if_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0h exp=1", bus.if_req_ready); end
        checks++; if (bus.ram_ridx !== 64'h0) begin failures++; $display("FAIL b2b_ridx1 got=%0h exp=0", bus.ram_ridx); end
        checks++; if (bus.mem_resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_mem_rvalid got=%0h exp=0", bus.mem_resp_valid); end
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        #1;
        checks++; if (bus.if_resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid1 got=%0h exp=1", bus.if_resp_valid); end
        checks++; if (bus.if_resp_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_data1 got=%0h exp=cafef00d", bus.if_resp_data); end
        checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL b2b_en2 got=%0h exp=0", bus.ram_en); end
        @(negedge clk);
        #1;
        checks++; if (bus.if_resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_rvalid2 got=%0h exp=0", bus.if_resp_valid); end
        idle_inputs();
        $display("test_if_back_to_back done");
    endtask

    task automatic test_mem_write_read();
        @(negedge clk);
        bus.mem_req_valid  = 1'b1;
        bus.mem_addr       = 64'h8000_0010;
        bus.mem_wen        = 1'b1;
        bus.mem_wdata      = 64'hDEAD_BEEF;
        bus.mem_wmask      = '1;
        bus.mem_resp_ready = 1'b1;
        #1;
        checks++; if (bus.mem_req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%0h exp=1", bus.mem_req_ready); end
        checks++; if (bus.ram_wen !== 1'b1) begin failures++; $display("FAIL wr_wen got=%0h exp=1", bus.ram_wen); end
        checks++; if (bus.ram_widx !== 64'h2) begin failures++; $display("FAIL wr_widx got=%0h exp=2", bus.ram_widx); end
        checks++; if (bus.ram_wdata !== 64'hDEAD_BEEF) begin failures++; $display("FAIL wr_wdata got=%0h exp=deadbeef", bus.ram_wdata); end
        checks++; if (bus.ram_wmask !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL wr_wmask got=%0h exp=ffffffffffffffff", bus.ram_wmask); end
        @(negedge clk);
        bus.mem_wen = 1'b0;
        #1;
        checks++; if (bus.mem_resp_valid !== 1'b1) begin failures++; $display("FAIL wr_rvalid got=%0h exp=1", bus.mem_resp_valid); end
        checks++; if (bus.mem_resp_data !== 64'h0) begin failures++; $display("FAIL wr_rdata got=%0h exp=0", bus.mem_resp_data); end
        checks++; if (bus.ram_wen !== 1'b0) begin failures++; $display("FAIL rd_wen got=%0h exp=0", bus.ram_wen); end
        checks++; if (bus.ram_ridx !== 64'h2) begin failures++; $display("FAIL rd_ridx got=%0h exp=2", bus.ram_ridx); end
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        #1;
        checks++; if (bus.mem_resp_data !== 64'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%0h exp=deadbeef", bus.mem_resp_data); end
        checks++; if (bus.if_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_if_rvalid got=%0h exp=0", bus.if_resp_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.mem_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_end got=%0h exp=0", bus.mem_resp_valid); end
        $display("test_mem_write_read done");
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h0;
        bus.if_resp_ready = 1'b1;
        #1;
        checks++; if (bus.ram_ridx !== 64'h1FFF_FFFF_F000_0000) begin failures++; $display("FAIL wrap_ridx got=%0h exp=1ffffffff0000000", bus.ram_ridx); end
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        #1;
        checks++; if (bus.if_resp_data !== 32'h1234_5678) begin failures++; $display("FAIL wrap_data got=%0h exp=12345678", bus.if_resp_data); end
        @(negedge clk);
        idle_inputs();
        $display("test_addr_wrap done");
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus.mem_req_valid  = 1'b1;
        bus.mem_addr       = 64'h8000_0018;
        bus.mem_resp_ready = 1'b0;
        #1;
        checks++; if (bus.mem_req_ready !== 1'b1) begin failures++; $display("FAIL hold_grant got=%0h exp=1", bus.mem_req_ready); end
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0000;
        #1;
        checks++; if (bus.mem_resp_data !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL hold_resp got=%0h exp=0123456789abcdef", bus.mem_resp_data); end
        checks++; if (bus.if_req_ready !== 1'b0) begin failures++; $display("FAIL hold_resp_ready got=%0h exp=0", bus.if_req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) bus.mem_resp_ready = 1'b1;
            #1;
            checks++; if (dut.state_reg !== 2'd2) begin failures++; $display("FAIL hold_state%0d got=%0d exp=2", i, dut.state_reg); end
            checks++; if (bus.mem_resp_valid !== 1'b1) begin failures++; $display("FAIL hold_rvalid%0d got=%0h exp=1", i, bus.mem_resp_valid); end
            checks++; if (bus.mem_resp_data !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL hold_data%0d got=%0h exp=0123456789abcdef", i, bus.mem_resp_data); end
            checks++; if (bus.if_req_ready !== 1'b0) begin failures++; $display("FAIL hold_if_ready%0d got=%0h exp=0", i, bus.if_req_ready); end
            checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL hold_en%0d got=%0h exp=0", i, bus.ram_en); end
        end
        @(negedge clk);
        bus.mem_resp_ready = 1'b0;
        bus.if_resp_ready  = 1'b1;
        #1;
        checks++; if (dut.state_reg !== 2'd0) begin failures++; $display("FAIL hold_idle got=%0d exp=0", dut.state_reg); end
        checks++; if (bus.mem_resp_valid !== 1'b0) begin failures++; $display("FAIL hold_rvalid_end got=%0h exp=0", bus.mem_resp_valid); end
        checks++; if (bus.if_req_ready !== 1'b1) begin failures++; $display("FAIL hold_next_grant got=%0h exp=1", bus.if_req_ready); end
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        #1;
        checks++; if (bus.if_resp_data !== 32'h1234_5678) begin failures++; $display("FAIL hold_if_data got=%0h exp=12345678", bus.if_resp_data); end
        @(negedge clk);
        idle_inputs();
        $display("test_hold done");
    endtask

    task automatic test_arbitration();
        logic [9:0] pat;
`ifdef ARB_RR_EN
        pat = 10'b10_1010_1010;
`else
        pat = 10'b10_0001_0000;
`endif
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst                = 1'b0;
        bus.if_req_valid   = 1'b1;
        bus.if_addr        = 64'h8000_0000;
        bus.if_resp_ready  = 1'b1;
        bus.mem_req_valid  = 1'b1;
        bus.mem_addr       = 64'h8000_0008;
        bus.mem_resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (bus.if_req_ready !== pat[i]) begin failures++; $display("FAIL arb_if_grant%0d got=%0h exp=%0h", i, bus.if_req_ready, pat[i]); end
            checks++; if (bus.mem_req_ready !== !pat[i]) begin failures++; $display("FAIL arb_mem_grant%0d got=%0h exp=%0h", i, bus.mem_req_ready, !pat[i]); end
            if (i > 0) begin
                checks++; if (bus.if_resp_valid !== pat[i-1]) begin failures++; $display("FAIL arb_if_rvalid%0d got=%0h exp=%0h", i, bus.if_resp_valid, pat[i-1]); end
                if (!pat[i-1]) begin
                    checks++; if (bus.mem_resp_data !== 64'h5555_AAAA_6666_9999) begin failures++; $display("FAIL arb_mem_data%0d got=%0h exp=5555aaaa66669999", i, bus.mem_resp_data); end
                end
            end
            $display("arb grant %0d: if=%0b mem=%0b", i, bus.if_req_ready, bus.mem_req_ready);
        end
        @(negedge clk);
        bus.if_req_valid  = 1'b0;
        bus.mem_req_valid = 1'b0;
        #1;
        checks++; if (bus.if_resp_data !== 32'h1234_5678) begin failures++; $display("FAIL arb_last_data got=%0h exp=12345678", bus.if_resp_data); end
        @(negedge clk);
        idle_inputs();
        $display("test_arbitration done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.mem_req_valid  = 1'b1;
        bus.mem_addr       = 64'h8000_0018;
        bus.mem_resp_ready = 1'b1;
        #1;
        checks++; if (bus.mem_req_ready !== 1'b1) begin failures++; $display("FAIL rmid_grant got=%0h exp=1", bus.mem_req_ready); end
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        #1;
        checks++; if (bus.mem_resp_valid !== 1'b1) begin failures++; $display("FAIL rmid_rvalid got=%0h exp=1", bus.mem_resp_valid); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (dut.state_reg !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", dut.state_reg); end
        checks++; if (bus.mem_resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rvalid_rst got=%0h exp=0", bus.mem_resp_valid); end
        checks++; if (bus.mem_resp_data !== 64'h0) begin failures++; $display("FAIL rmid_data got=%0h exp=0", bus.mem_resp_data); end
        checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL rmid_en got=%0h exp=0", bus.ram_en); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.mem_resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_after_rvalid got=%0h exp=0", bus.mem_resp_valid); end
        checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL rmid_after_en got=%0h exp=0", bus.ram_en); end
        $display("test_reset_mid done");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_if_back_to_back();
        test_mem_write_read();
        test_addr_wrap();
        test_hold();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAMHelper port between instruction fetch (IF) and the data load/store unit (MEM).
- Accepts one request per grant using a valid/ready handshake and drives the RAMHelper index, write and enable signals.
- Returns the read data to the request's owner and holds it until that owner accepts it.
- Sits between if_stage / mem_stage and the RAMHelper instance at the core top level.

Parameters:
- PC_BASE, 64'h0000_0000_8000_0000, physical base of RAM; index = (addr - PC_BASE) >> 3.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win (fixed-priority mode only).
- CNT_W, 3, width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF fetch request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  64  fetch byte address, 4-byte aligned
- if_resp_valid  out  1  fetch data valid
- if_resp_ready  in  1  IF consumes the response
- if_resp_data  out  32  instruction word
- mem_req_valid  in  1  MEM request
- mem_req_ready  out  1  MEM request accepted this cycle
- mem_addr  in  64  byte address, 8-byte granule
- mem_wen  in  1  1 = write, 0 = read
- mem_wdata  in  64  write data
- mem_wmask  in  64  per-bit write mask
- mem_resp_valid  out  1  MEM response valid
- mem_resp_ready  in  1  MEM consumes the response
- mem_resp_data  out  64  read data; 0 for writes
- ram_en  out  1  RAMHelper enable
- ram_ridx  out  64  RAMHelper read index
- ram_rdata  in  64  RAMHelper read data, valid the cycle after ram_en
- ram_widx  out  64  write index
- ram_wdata  out  64  write data
- ram_wmask  out  64  write mask
- ram_wen  out  1  write enable

Behaviour:
- States: IDLE, RESP, HOLD. Reset → IDLE.
  - On reset: all ready/valid/ram_* outputs 0, response data 0, starvation counter 0, hold register 0.
- Grant window:
  - Open in IDLE.
  - Open in RESP when the owner's resp_ready=1 in that same cycle (back-to-back, one access per cycle).
  - Closed in HOLD.
- Arbitration:
  - Only the winner sees ready=1; the loser sees 0. Both requests are combinational functions of the current valids.
  - Default winner is MEM.
  - IF wins when mem_req_valid=0, or when the starvation counter equals STARVE_MAX.
- Grant cycle:
  - ram_en=1 and ram_ridx=(addr-PC_BASE)>>3, 64-bit unsigned; addresses below PC_BASE wrap modulo 2^64 without error.
  - MEM write: also ram_wen=1, ram_widx=ram_ridx, ram_wdata/ram_wmask driven from mem_wdata/mem_wmask.
  - Latched: owner, addr[2], write flag. Next state = RESP.
  - ram_en and ram_wen are high only in grant cycles.
- RESP:
  - The owner's resp_valid=1.
  - Response data:
    - IF: addr[2] ? ram_rdata[63:32] : ram_rdata[31:0].
    - MEM read: ram_rdata.
    - MEM write: 64'h0.
  - Data is also captured into the hold register.
  - resp_ready=1 → IDLE, or RESP if a new grant happens in the same cycle.
  - resp_ready=0 → HOLD.
- HOLD: the owner's resp_valid=1, data from the hold register (stable). On resp_ready=1 → IDLE; no grant in that cycle.
- The non-owner's resp_valid is always 0. At most one outstanding access.
- Starvation counter:
  - +1, saturating at STARVE_MAX, on every grant cycle where if_req_valid=1 and MEM wins.
  - Cleared on an IF grant, or in any cycle with if_req_valid=0.
- Reset mid-operation: the pending response is dropped and the state returns to IDLE. No resp_valid and no ram_en in the cycle after rst deasserts unless a new grant occurs.
- Simultaneous valid in both requesters is resolved as above; the loser holds its request stable (requester rule).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin replaces fixed priority: when both requesters are valid, the one not granted last wins.
  - A last-grant flag resets to IF, so MEM wins the first tie.
  - The starvation counter is not built.
- Undefined: fixed MEM priority with the STARVE_MAX override, as above.

Test Plan:
- Reset, then IF-only requests at 0x8000_0000 and 0x8000_0004 back-to-back with resp_ready=1:
  - ram_ridx = 0 then 0.
  - if_resp_data = rdata[31:0] then rdata[63:32].
  - One response per cycle.
- MEM write 0x8000_0010, wdata=0xDEAD_BEEF, wmask=all-ones; then a read of the same address:
  - ram_wen=1 with widx=2.
  - First response data=0.
  - Read returns 0xDEAD_BEEF.
- Both valid every cycle for 10 grants (default build):
  - Grant order MEM×4, IF, MEM×4, IF.
- mem_resp_ready held 0 for 3 cycles after a read:
  - State HOLD; mem_resp_data stable; ready signals 0; no ram_en.
  - Release → IDLE, then the next grant one cycle later.
- rst asserted in RESP:
  - Next cycle all outputs 0, state IDLE, no stale resp_valid.
- With ARB_RR_EN, both requesters always valid:
  - Grant order MEM, IF, MEM, IF …
